// File: rtl/glitch_seq.sv
// Trigger-driven glitch campaign sequencer: waits for a selected trigger edge,
// issues a glitch request, then steps the delay for the next attempt.
module glitch_seq (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        arm,
    input  logic        abort,
    input  logic        trig_in,
    input  logic        trig_pol,
    input  logic [15:0] delay_start,
    input  logic [15:0] delay_step,
    input  logic [7:0]  width,
    input  logic [7:0]  mode,
    input  logic [7:0]  count,
    input  logic        glitch_ready,
    output logic        glitch_en,
    output logic [15:0] glitch_delay,
    output logic [7:0]  glitch_width,
    output logic [7:0]  glitch_mode,
    output logic        busy,
    output logic        done,
    output logic [7:0]  attempt,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        trig_p0;
    logic        trig_p1;
    logic        trig_p2;
    logic        edge_sel;
    logic        arm_acc;

    logic        pol_q;
    logic [15:0] step_q;
    logic [7:0]  count_q;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Stage p0/p1: metastability synchroniser; p2: previous value for edge detect
    always_ff @(posedge clk_in) begin
        if (rst) begin
            trig_p0 <= 1'b0;
            trig_p1 <= 1'b0;
            trig_p2 <= 1'b0;
        end else begin
            trig_p0 <= trig_in;
            trig_p1 <= trig_p0;
            trig_p2 <= trig_p1;
        end
    end

    assign edge_sel = pol_q ? (trig_p1 & ~trig_p2) : (~trig_p1 & trig_p2);
    assign arm_acc  = (state == IDLE) && arm && !abort;

    // Campaign configuration, captured on an accepted arm only
    always_ff @(posedge clk_in) begin
        if (arm_acc) begin
            pol_q   <= trig_pol;
            step_q  <= delay_step;
            count_q <= count;
        end
    end

    always_comb begin
        state_nxt = state;
        glitch_en = 1'b0;
        case (state)
            IDLE: begin
                if (arm_acc && (count != 8'd0))
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (abort)
                    state_nxt = IDLE;
                else if (edge_sel && glitch_ready)
                    state_nxt = FIRE;
            end
            FIRE: begin
                glitch_en = 1'b1;
                state_nxt = abort ? IDLE : WAIT;
            end
            WAIT: begin
                if (abort)
                    state_nxt = IDLE;
                else if (glitch_ready)
                    state_nxt = (attempt == count_q) ? IDLE : ARMED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            attempt      <= 8'd0;
            overrun      <= 1'b0;
            glitch_delay <= 16'd0;
            glitch_width <= 8'd0;
            glitch_mode  <= 8'd0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm_acc) begin
                        attempt      <= 8'd0;
                        overrun      <= 1'b0;
                        glitch_delay <= delay_start;
                        glitch_width <= width;
                        glitch_mode  <= mode;
                        done         <= (count == 8'd0);
                    end
                end
                ARMED: begin
                    if (!abort && edge_sel && !glitch_ready)
                        overrun <= 1'b1;
                end
                FIRE: begin
                    if (!abort)
                        attempt <= attempt + 8'd1;
                end
                WAIT: begin
                    // Edges seen here are deliberately ignored; only ready matters
                    if (!abort && glitch_ready) begin
                        if (attempt == count_q)
                            done <= 1'b1;
                        else
                            glitch_delay <= sat_add16(glitch_delay, step_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_seq.sv
// Bench for glitch_seq: directed scenarios plus randomized campaigns, with a
// scoreboard monitor checking every glitch_en and done pulse.
module tb_glitch_seq;

    logic        clk_in = 1'b0;
    logic        rst, arm, abort, trig_in, trig_pol, glitch_ready;
    logic [15:0] delay_start, delay_step;
    logic [7:0]  width, mode, count;
    logic        glitch_en, busy, done, overrun;
    logic [15:0] glitch_delay;
    logic [7:0]  glitch_width, glitch_mode, attempt;

    always #5 clk_in = ~clk_in;

    glitch_seq dut (
        .clk_in(clk_in), .rst(rst), .arm(arm), .abort(abort), .trig_in(trig_in),
        .trig_pol(trig_pol), .delay_start(delay_start), .delay_step(delay_step),
        .width(width), .mode(mode), .count(count), .glitch_ready(glitch_ready),
        .glitch_en(glitch_en), .glitch_delay(glitch_delay), .glitch_width(glitch_width),
        .glitch_mode(glitch_mode), .busy(busy), .done(done), .attempt(attempt),
        .overrun(overrun)
    );

    typedef struct {
        logic [15:0] d;
        logic [7:0]  w;
        logic [7:0]  m;
        logic [7:0]  a;
    } exp_t;

    exp_t        gq[$];
    logic [7:0]  dq[$];
    int          total = 0;
    int          bad = 0;

    // Reference campaign parameters
    bit          c_pol;
    logic [15:0] c_start, c_step;
    logic [7:0]  c_w, c_m, c_cnt;
    int          c_fired;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Delay of attempt i is start + i*step, clipped to the 16-bit maximum
    function automatic logic [15:0] model_delay(input int i);
        longint v;
        v = longint'(c_start) + longint'(i) * longint'(c_step);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    always @(negedge clk_in) begin
        if (glitch_en === 1'b1) begin
            if (gq.size() == 0) begin
                chk("glitch_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = gq.pop_front();
                chk("glitch_delay", glitch_delay, e.d);
                chk("glitch_width", glitch_width, e.w);
                chk("glitch_mode", glitch_mode, e.m);
                chk("glitch_attempt", attempt, e.a);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                logic [7:0] a;
                a = dq.pop_front();
                chk("done_attempt", attempt, a);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_arm(input bit pol, input logic [15:0] st, input logic [15:0] sp,
                          input logic [7:0] w, input logic [7:0] m, input logic [7:0] c);
        trig_pol = pol; delay_start = st; delay_step = sp;
        width = w; mode = m; count = c;
        c_pol = pol; c_start = st; c_step = sp; c_w = w; c_m = m; c_cnt = c; c_fired = 0;
        if (c == 8'd0)
            dq.push_back(8'd0);
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
        chk("arm_busy", busy, (c != 8'd0));
        chk("arm_attempt", attempt, 32'd0);
        chk("arm_overrun", overrun, 32'd0);
    endtask

    // act: 0 = normal, 1 = remain in WAIT (ready low), 2 = reset while in FIRE
    task automatic do_attempt(input int hold, input bit noise, input int act);
        exp_t e;
        bit   got;
        trig_in = ~c_pol;
        cyc(5);
        e.d = model_delay(c_fired); e.w = c_w; e.m = c_m; e.a = 8'(c_fired);
        gq.push_back(e);
        if (act == 0 && c_fired + 1 == int'(c_cnt))
            dq.push_back(c_cnt);
        trig_in = c_pol;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            if (glitch_en) begin
                got = 1'b1;
                break;
            end
        end
        chk("glitch_seen", got, 32'd1);
        if (!got) return;
        c_fired++;
        if (act == 2) begin
            rst = 1'b1;
            cyc(1);
            chk("rst_glitch_en", glitch_en, 32'd0);
            chk("rst_delay", glitch_delay, 32'd0);
            chk("rst_width", glitch_width, 32'd0);
            chk("rst_mode", glitch_mode, 32'd0);
            chk("rst_busy", busy, 32'd0);
            chk("rst_done", done, 32'd0);
            chk("rst_attempt", attempt, 32'd0);
            chk("rst_overrun", overrun, 32'd0);
            cyc(2);
            rst = 1'b0;
            cyc(3);
            chk("post_rst_busy", busy, 32'd0);
            return;
        end
        if (act == 1) begin
            glitch_ready = 1'b0;
            cyc(2);
            return;
        end
        if (hold > 0) begin
            glitch_ready = 1'b0;
            if (noise) begin
                cyc(1);
                trig_in = ~c_pol;
                cyc(2);
                trig_in = c_pol;
            end
            cyc(hold);
            glitch_ready = 1'b1;
        end
        cyc(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0; trig_pol = 1'b1;
        glitch_ready = 1'b1; delay_start = '0; delay_step = '0;
        width = '0; mode = '0; count = '0;
        cyc(3);
        chk("reset_glitch_en", glitch_en, 32'd0);
        chk("reset_delay", glitch_delay, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_done", done, 32'd0);
        chk("reset_attempt", attempt, 32'd0);
        chk("reset_overrun", overrun, 32'd0);
        rst = 1'b0;
        cyc(3);

        // Basic sweep
        do_arm(1'b1, 16'd100, 16'd10, 8'd5, 8'd2, 8'd3);
        for (int i = 0; i < 3; i++) do_attempt(0, 1'b0, 0);
        chk("sweep_attempt", attempt, 32'd3);
        chk("sweep_busy", busy, 32'd0);

        // Saturation
        do_arm(1'b1, 16'hFFF0, 16'h0010, 8'd7, 8'd1, 8'd3);
        for (int i = 0; i < 3; i++) do_attempt(1, 1'b0, 0);
        chk("sat_attempt", attempt, 32'd3);

        // Overrun: edge while generator not ready
        do_arm(1'b1, 16'd200, 16'd1, 8'd9, 8'd4, 8'd2);
        glitch_ready = 1'b0;
        trig_in = 1'b0;
        cyc(5);
        trig_in = 1'b1;
        cyc(6);
        chk("overrun_set", overrun, 32'd1);
        chk("overrun_busy", busy, 32'd1);
        glitch_ready = 1'b1;
        do_attempt(0, 1'b0, 0);
        chk("overrun_sticky", overrun, 32'd1);
        do_attempt(0, 1'b0, 0);
        chk("overrun_end", overrun, 32'd1);

        // Abort in WAIT after two attempts
        do_arm(1'b1, 16'd50, 16'd5, 8'd3, 8'd3, 8'd4);
        do_attempt(0, 1'b0, 0);
        do_attempt(0, 1'b0, 1);
        chk("wait_busy", busy, 32'd1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_busy", busy, 32'd0);
        chk("abort_attempt", attempt, 32'd2);
        chk("abort_glitch_en", glitch_en, 32'd0);
        glitch_ready = 1'b1;
        cyc(3);
        chk("abort_idle", busy, 32'd0);

        // count = 0 gives a bare done pulse
        do_arm(1'b1, 16'd1, 16'd1, 8'd11, 8'd12, 8'd0);
        cyc(2);
        chk("cnt0_busy", busy, 32'd0);

        // arm with abort: nothing starts, width/mode untouched
        width = 8'hAA; mode = 8'hBB; count = 8'd2;
        arm = 1'b1; abort = 1'b1;
        cyc(1);
        arm = 1'b0; abort = 1'b0;
        cyc(1);
        chk("armabort_busy", busy, 32'd0);
        chk("armabort_width", glitch_width, 32'd11);
        chk("armabort_mode", glitch_mode, 32'd12);

        // Reset while in FIRE
        do_arm(1'b1, 16'd300, 16'd3, 8'd1, 8'd1, 8'd3);
        do_attempt(0, 1'b0, 2);

        // Falling-edge polarity; rising edges must not fire
        do_arm(1'b0, 16'd400, 16'd20, 8'd6, 8'd6, 8'd2);
        for (int i = 0; i < 2; i++) do_attempt(0, 1'b0, 0);
        chk("fall_attempt", attempt, 32'd2);

        // Randomized campaigns; some with trigger noise while in WAIT
        for (int r = 0; r < 10; r++) begin
            logic [15:0] st;
            logic [7:0]  cn;
            st = ($urandom_range(0, 1) == 1) ? (16'hFF00 | 16'($urandom_range(0, 255)))
                                            : 16'($urandom);
            cn = 8'($urandom_range(1, 4));
            do_arm(1'($urandom_range(0, 1)), st, 16'($urandom_range(0, 600)),
                   8'($urandom), 8'($urandom), cn);
            for (int i = 0; i < int'(cn); i++) begin
                if (r % 3 == 0) do_attempt(6 + $urandom_range(0, 2), 1'b1, 0);
                else            do_attempt($urandom_range(0, 3), 1'b0, 0);
                chk("rand_overrun", overrun, 32'd0);
            end
            chk("rand_attempt", attempt, 32'(cn));
            chk("rand_busy", busy, 32'd0);
        end

        cyc(4);
        chk("glitch_queue_empty", gq.size(), 32'd0);
        chk("done_queue_empty", dq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glitch_seq.md
GLITCH_SEQ -- requirements
Module: glitch_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as listed below, clock and reset first.
- clk_in  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- arm  in  1  one-cycle request to start a campaign; sampled in IDLE only.
- abort  in  1  one-cycle request to cancel the campaign; priority over arm.
- trig_in  in  1  asynchronous external trigger.
- trig_pol  in  1  trigger edge select: 1 = rising, 0 = falling; latched on arm.
- delay_start  in  16  first-attempt delay; latched on arm.
- delay_step  in  16  per-attempt delay increment; latched on arm.
- width  in  8  glitch width; latched on arm.
- mode  in  8  glitch mode; latched on arm.
- count  in  8  number of attempts; latched on arm.
- glitch_ready  in  1  ready from the downstream glitch generator.
- glitch_en  out  1  one-cycle start pulse to the glitch generator.
- glitch_delay  out  16  delay presented with glitch_en.
- glitch_width  out  8  width presented with glitch_en.
- glitch_mode  out  8  mode presented with glitch_en.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a campaign completes normally.
- attempt  out  8  number of attempts fired in the current campaign.
- overrun  out  1  sticky flag: a trigger edge was dropped because the generator was not ready.

Function
REQ-003 trig_in SHALL pass through a 2-flop synchroniser, then a third register for edge detection; the edge is valid 3 cycles after the pin changes.
REQ-004 The states SHALL be IDLE, ARMED, FIRE and WAIT, encoded in 2 bits.
REQ-005 IDLE with arm=1 and abort=0: latch all inputs, set attempt=0, clear overrun, set glitch_delay=delay_start, and go to ARMED; if count=0, instead pulse done next cycle and stay in IDLE.
REQ-006 ARMED: on a selected edge with glitch_ready=1, go to FIRE; on a selected edge with glitch_ready=0, set overrun=1 and stay in ARMED.
REQ-007 FIRE: glitch_en=1 for exactly this one cycle; glitch_delay, glitch_width and glitch_mode SHALL stay stable; attempt increments by 1; next state is WAIT.
REQ-008 WAIT: glitch_en=0; leave only when glitch_ready=1, sampled no earlier than the cycle after FIRE.
REQ-009 On leaving WAIT with attempt==count, pulse done for one cycle and go to IDLE.
REQ-010 On leaving WAIT with attempt<count, set glitch_delay to glitch_delay+delay_step, saturating at 16'hFFFF with no wrap, and go to ARMED; a fresh trigger edge is required for each attempt.
REQ-011 Edges arriving in FIRE or WAIT SHALL be discarded and SHALL NOT set overrun.
REQ-012 abort=1 in any state other than IDLE: go to IDLE next cycle with glitch_en=0 and no done pulse; attempt and overrun hold their values.
REQ-013 Simultaneous abort and arm in IDLE: abort wins and no campaign starts.
REQ-014 arm while not in IDLE SHALL be ignored.
REQ-015 glitch_width and glitch_mode SHALL change only on an accepted arm.
REQ-016 busy SHALL be a registered decode of state!=IDLE.

Reset
REQ-017 While rst=1, the block SHALL hold state=IDLE, glitch_en=0, glitch_delay=0, glitch_width=0, glitch_mode=0, busy=0, done=0, attempt=0, overrun=0, and the synchroniser flops at 0.
REQ-018 rst asserted mid-campaign, including in FIRE, SHALL take effect at the next edge with no done pulse.
REQ-019 The first cycle after rst deasserts SHALL NOT detect a trigger edge.

Verification
REQ-020 Basic sweep: arm with delay_start=100, step=10, width=5, mode=2, count=3, trig_pol=1; three rising edges, each with ready=1 -> three glitch_en pulses with glitch_delay 100, 110, 120, attempt ending at 3, one done pulse.
REQ-021 Saturation: delay_start=16'hFFF0, step=16'h0010, count=3 -> glitch_delay sequence FFF0, FFFF, FFFF.
REQ-022 Overrun: hold glitch_ready=0 while in ARMED and apply a rising edge -> overrun=1, no glitch_en; release ready and apply another edge -> glitch_en pulses and overrun stays 1.
REQ-023 Abort: abort while in WAIT with count=4 after 2 attempts -> IDLE next cycle, busy=0, attempt=2, no done pulse.
REQ-024 Edge cases: count=0 -> done pulse only, no glitch_en; arm and abort together in IDLE -> busy stays 0.
REQ-025 Reset and polarity: rst in FIRE -> all outputs at reset values next cycle; trig_pol=0 -> only falling edges fire.
